// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the instruction memory. A length-prefixed,
// little-endian byte stream arrives over a valid/ready handshake. The first
// two bytes give the word count N; the next 4*N bytes are the words, least
// significant byte first. Each completed word is written to the instruction
// memory with a registered one-cycle strobe, at byte address word_index*4.
// The core is held in reset until the whole image has been written.
//
// Parameters:
//   DEPTH      instruction memory depth in 32-bit words (max loadable count)
//   ADDR_W     width of the byte write address
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle pulse that begins a load (IDLE, DONE, ERR only)
//   i_in_valid   stream byte on i_in_data is valid
//   i_in_data    stream byte
//   o_in_ready   loader accepts a byte this cycle
//   o_we         one-cycle instruction memory write strobe
//   o_waddr      byte write address (always word aligned)
//   o_wdata      assembled 32-bit word
//   o_cpu_hold   high keeps the core in reset
//   o_done       high after a successful load, until the next start
//   o_err        high after a bad header, until the next start
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_LAST,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [15:0]        r_cnt;
  logic [15:0]        r_wordIdx;
  logic [1:0]         r_byteIdx;
  logic [23:0]        r_shift;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [31:0]        r_wdata;

  logic               w_accept;
  logic [15:0]        w_hdrCount;
  logic               w_hdrBad;
  logic               w_wordDone;
  logic               w_lastWord;

  // The loader only listens to the stream while parsing header or payload,
  // so the ready flag is a pure decode of the state register.
  assign o_in_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                      (r_state == S_DATA);
  assign w_accept   = i_in_valid && o_in_ready;

  // The count is complete on the second header byte, so the range check
  // uses the incoming high byte together with the stored low byte.
  assign w_hdrCount = {i_in_data, r_cnt[7:0]};
  assign w_hdrBad   = (w_hdrCount == 16'd0) || ({16'd0, w_hdrCount} > DEPTH_U);

  // A payload byte accepted in slot 3 completes a word; if that word is the
  // N-th one the image is finished.
  assign w_wordDone = (r_state == S_DATA) && w_accept && (r_byteIdx == 2'd3);
  assign w_lastWord = (r_wordIdx == (r_cnt - 16'd1));

  assign o_we    = r_we;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the status outputs. The status flags are decoded
  // from the state register so that an asynchronous reset returns them to
  // their idle values immediately.
  always_comb begin
    w_nextState = r_state;
    o_cpu_hold  = 1'b1;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_nextState = S_HDR0;
      end
      S_HDR0: begin
        if (w_accept) w_nextState = S_HDR1;
      end
      S_HDR1: begin
        if (w_accept) w_nextState = w_hdrBad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_wordDone && w_lastWord) w_nextState = S_LAST;
      end
      S_LAST: begin
        // This cycle carries the final write strobe; the core is released
        // only on the following cycle.
        w_nextState = S_DONE;
      end
      S_DONE: begin
        o_cpu_hold = 1'b0;
        o_done     = 1'b1;
        if (i_start) w_nextState = S_HDR0;
      end
      S_ERR: begin
        o_err = 1'b1;
        if (i_start) w_nextState = S_HDR0;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Header capture, byte assembly and the registered write port. The write
  // strobe defaults low every cycle, so it can never stay high for two
  // cycles; address and data simply hold between writes. The shift register
  // is never cleared because every byte slot is rewritten before each write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= 16'd0;
      r_wordIdx <= 16'd0;
      r_byteIdx <= 2'd0;
      r_shift   <= 24'd0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= 32'd0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HDR0: begin
          if (w_accept) r_cnt[7:0] <= i_in_data;
        end
        S_HDR1: begin
          if (w_accept) begin
            r_cnt[15:8] <= i_in_data;
            r_wordIdx   <= 16'd0;
            r_byteIdx   <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_byteIdx <= r_byteIdx + 2'd1;
            case (r_byteIdx)
              2'd0: r_shift[7:0]   <= i_in_data;
              2'd1: r_shift[15:8]  <= i_in_data;
              2'd2: r_shift[23:16] <= i_in_data;
              default: begin
                // The top byte goes straight into the write data, so the
                // word is presented on the very next cycle.
                r_we      <= 1'b1;
                r_wdata   <= {i_in_data, r_shift};
                r_waddr   <= ADDR_W'({r_wordIdx, 2'b00});
                r_wordIdx <= r_wordIdx + 16'd1;
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream before the core runs. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and issues one registered write per word at word-aligned byte addresses from 0. It holds the core in reset (`cpu_hold`) until the image is fully written. It sits between the host/boot byte source and the instruction memory write port, which is the counterpart of that memory's combinational read port.

## Interface
- `DEPTH`, 256, instruction memory depth in 32-bit words; the maximum loadable word count.
- `ADDR_W`, 32, width of `waddr`; a byte address, so `waddr[1:0]` is always 0.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready` is high at a clock edge.
- `we`  out  1  one-cycle write strobe to the instruction memory.
- `waddr`  out  ADDR_W  byte address, equal to word_index*4.
- `wdata`  out  32  assembled word.
- `cpu_hold`  out  1  high keeps the core in reset.
- `done`  out  1  level; high after a successful load, until the next `start`.
- `err`  out  1  level; high after a bad header, until the next `start`.

## Operation
- Stream format: CNT_LO, CNT_HI (16-bit word count N), then N words of 4 bytes each, least significant byte first.
- States and transitions:
  - IDLE: the reset state. `in_ready`=0 and `cpu_hold`=1. `start` moves to HDR0.
  - HDR0: `in_ready`=1. An accepted byte sets cnt[7:0] and moves to HDR1.
  - HDR1: `in_ready`=1. An accepted byte sets cnt[15:8]. If {byte,cnt[7:0]} is 0 or greater than DEPTH, go to ERR; otherwise go to DATA with word_idx=0 and byte_idx=0.
  - DATA: `in_ready`=1. An accepted byte goes into shift[8*byte_idx +: 8], and byte_idx increments modulo 4.
    - On the 4th byte: the next cycle has `we`=1, `wdata`=the completed word, `waddr`=word_idx*4, and word_idx increments.
    - If that 4th byte completes word N-1, go to LAST instead of staying in DATA.
  - LAST: `in_ready`=0. This is the cycle of the final `we` pulse. Go unconditionally to DONE.
  - DONE: `in_ready`=0, `cpu_hold`=0, `done`=1. `start` moves to HDR0 and reasserts `cpu_hold` and clears `done` on the same edge.
  - ERR: `in_ready`=0, `cpu_hold`=1, `err`=1. `start` moves to HDR0 and clears `err`.
- `start` in HDR0, HDR1, DATA or LAST is ignored.
- `in_valid` may drop at any time, including mid-word. Byte assembly simply pauses; there is no timeout.
- Bytes offered while `in_ready`=0 are not consumed.
- The shift register is not cleared between words. Every byte position is overwritten before each write.
- `we` is registered and never high for two consecutive cycles.
- `waddr` and `wdata` hold their last values while `we`=0.

## Timing
- Reset values: `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `done`=0, `err`=0. State is IDLE and all counters are 0.
- Write latency: `we` is high exactly 1 cycle after the edge that accepts byte 3 of a word.
- Back-to-back stream: with `in_valid` held high, one byte is accepted per cycle.
  - Word k's write occurs on the cycle when byte 0 of word k+1 is accepted.
  - A full load takes 2+4N accept cycles, then LAST, then DONE.
- `done` and `cpu_hold`=0 first appear 1 cycle after the final `we`. The core therefore never fetches in the same cycle as the final write.
- Reset asserted mid-operation immediately (asynchronously) returns every output to its reset value. Any partially assembled word is discarded and is not written.
- A header of exactly DEPTH is legal; the last write is to waddr=(DEPTH-1)*4.

## Test plan
- Minimal load: reset, `start`, stream 01 00 13 05 A0 00 with `in_valid` held high → a single `we` with `waddr`=0x0 and `wdata`=0x00A00513; `done`=1 and `cpu_hold`=0 exactly 2 cycles after the last byte is accepted.
- Stalled load: N=3, with `in_valid` dropped for 2 cycles after every byte → writes of 0x11111111, 0x22222222, 0x33333333 at 0x0, 0x4 and 0x8; no extra or duplicate `we` pulses.
- Header bounds: count 00 00 → `err`=1 with `cpu_hold`=1 and no `we`; count 01 01 (257) → `err`=1. After `start`, a valid count of 00 01 (256) loads 256 words, the last at 0x3FC.
- Ignored start: pulse `start` during DATA mid-word → the load completes unchanged with the same write sequence and no return to HDR0.
- Reset mid-load: assert `rst_n` low after 2 bytes of word 1 → all outputs immediately take their reset values. A subsequent fresh load completes normally.
- Reload: after DONE, `start` → `cpu_hold` returns to 1 and `done` to 0 on the same edge. A second image overwrites from address 0.
